// File: rtl/ucsbece154a_uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
// Register offsets are byte offsets within the 8-byte window; STATUS bit positions are listed here.
package ucsbece154a_uart_pkg;

  typedef enum logic [1:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_STOP
  } uart_state_t;

  localparam logic [2:0] UART_DATA_OFS   = 3'd0;
  localparam logic [2:0] UART_STATUS_OFS = 3'd4;

  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_BUSY      = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_COUNT_LSB = 8;

endpackage

// File: rtl/ucsbece154a_fifo.sv
// Circular-buffer FIFO, head visible combinationally on dout; push when full and pop when empty are ignored.
// Count is one bit wider than the pointers so full and empty are distinguishable.
module ucsbece154a_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ucsbece154a_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: DATA/STATUS register window, byte FIFO, registered TX line.
// A push starts a frame one edge later; no bus stall, a push into a full FIFO is dropped and flagged as overflow.
module ucsbece154a_uart_tx
  import ucsbece154a_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we_i,
  input  logic [31:0] a_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd_o,
  output logic        hit_o,
  output logic        tx_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  uart_state_t   state, state_n;
  logic [BW-1:0] baud_cnt, baud_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          overflow;

  logic [2:0]    ofs;
  logic          push_req;
  logic          status_wr;
  logic          pop;
  logic [7:0]    head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          unused_bits;

  assign unused_bits = ^{a_i[1:0], wd_i[31:8]};
  assign hit_o       = (a_i[31:3] == BASE_ADDR[31:3]);
  assign ofs         = {a_i[2], 2'b00};
  assign push_req    = we_i && hit_o && (ofs == UART_DATA_OFS);
  assign status_wr   = we_i && hit_o && (ofs == UART_STATUS_OFS);

  ucsbece154a_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (wd_i[7:0]),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    rd_o = '0;
    if (hit_o && ofs == UART_STATUS_OFS) begin
      rd_o[ST_FULL]              = full;
      rd_o[ST_EMPTY]             = empty;
      rd_o[ST_BUSY]              = (state != UART_IDLE);
      rd_o[ST_OVF]               = overflow;
      rd_o[ST_COUNT_LSB +: CW]   = count;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               overflow <= 1'b0;
    else if (status_wr)      overflow <= 1'b0;
    else if (push_req && full) overflow <= 1'b1;
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt + 1'b1;
    bit_n   = bit_cnt;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      UART_IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          state_n = UART_START;
        end
      end
      UART_START: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_n  = '0;
          state_n = UART_DATA;
        end
      end
      UART_DATA: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_n  = '0;
          shift_n = {1'b0, shift[7:1]};
          bit_n   = bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) state_n = UART_STOP;
        end
      end
      UART_STOP: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_n = '0;
          bit_n  = '0;
          // Chain straight into the next start bit so queued bytes leave with no idle gap.
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
            state_n = UART_START;
          end else begin
            state_n = UART_IDLE;
          end
        end
      end
      default: state_n = UART_IDLE;
    endcase

    case (state_n)
      UART_START: tx_n = 1'b0;
      UART_DATA:  tx_n = shift_n[0];
      default:    tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= UART_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_o     <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      tx_o     <= tx_n;
    end
  end

endmodule

// File: tb/tb_ucsbece154a_uart_tx.sv
// Bench for the UART transmitter: scenario tasks plus a serial-line monitor checking received bytes against a queue.
module tb_ucsbece154a_uart_tx;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] ST_ADDR = BASE + 32'd4;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        hit;
  logic        tx;

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q [$];
  logic mon_en = 1'b0;
  logic rx_busy = 1'b0;

  ucsbece154a_uart_tx #(
    .BASE_ADDR    (BASE),
    .CLKS_PER_BIT (4),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .we_i  (we),
    .a_i   (a),
    .wd_i  (wd),
    .rd_o  (rd),
    .hit_o (hit),
    .tx_o  (tx)
  );

  always #5 clk = ~clk;

  // Serial-line monitor: mid-bit sampling, 4 clocks per bit.
  initial begin
    logic [7:0] rx_byte;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && tx === 1'b0) begin
        rx_busy = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (tx !== 1'b0) begin
          bad++;
          $display("FAIL rx_start got=%b exp=0", tx);
        end
        for (int b = 0; b < 8; b++) begin
          repeat (4) @(negedge clk);
          rx_byte[b] = tx;
        end
        repeat (4) @(negedge clk);
        total++;
        if (tx !== 1'b1) begin
          bad++;
          $display("FAIL rx_stop got=%b exp=1", tx);
        end
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL rx_unexpected got=%02h exp=none", rx_byte);
        end else begin
          exp_b = exp_q.pop_front();
          if (rx_byte !== exp_b) begin
            bad++;
            $display("FAIL rx_byte got=%02h exp=%02h", rx_byte, exp_b);
          end
        end
        @(negedge clk);
        rx_busy = 1'b0;
      end
    end
  end

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    we = 1'b1;
    a  = addr;
    wd = data;
  endtask

  task automatic bus_idle();
    @(negedge clk);
    we = 1'b0;
    a  = 32'h0;
    wd = 32'h0;
  endtask

  task automatic read_status(output logic [31:0] v);
    we = 1'b0;
    a  = ST_ADDR;
    #1;
    v = rd;
  endtask

  task automatic wait_idle(input int budget, input string name);
    logic [31:0] s;
    logic done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      read_status(s);
      if (!s[2] && !rx_busy && exp_q.size() == 0) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s_timeout got=busy/pending exp=idle within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    logic [31:0] s;
    reset = 1'b1;
    we = 1'b0; a = 32'h0; wd = 32'h0;
    repeat (3) @(negedge clk);
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b exp=1", tx); end
    reset = 1'b0;
    read_status(s);
    total++;
    if (s !== 32'h2) begin bad++; $display("FAIL reset_status got=%h exp=00000002", s); end

    // Mid-frame reset with bytes still queued.
    bus_write(BASE, 32'h00);
    bus_write(BASE, 32'h00);
    bus_write(BASE, 32'h00);
    bus_idle();
    repeat (10) @(negedge clk);
    read_status(s);
    total++;
    if (s !== 32'h0000_0204) begin bad++; $display("FAIL midframe_status got=%h exp=00000204", s); end
    total++;
    if (tx !== 1'b0) begin bad++; $display("FAIL midframe_tx got=%b exp=0", tx); end
    #1;
    reset = 1'b1;
    #1;
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL async_reset_tx got=%b exp=1", tx); end
    @(negedge clk);
    reset = 1'b0;
    read_status(s);
    total++;
    if (s !== 32'h2) begin bad++; $display("FAIL post_reset_status got=%h exp=00000002", s); end
    repeat (50) @(negedge clk);
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL abandoned_frame_tx got=%b exp=1", tx); end
    mon_en = 1'b1;
  endtask

  task automatic test_single_byte();
    logic [9:0]  fr;
    logic [31:0] s;
    fr = {1'b1, 8'hA5, 1'b0};
    exp_q.push_back(8'hA5);
    bus_write(BASE, 32'h0000_00A5);
    bus_idle();
    #1;
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL single_latency_n got=%b exp=1", tx); end
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) repeat (4) @(negedge clk);
      #1;
      total++;
      if (tx !== fr[i]) begin bad++; $display("FAIL single_bit%0d got=%b exp=%b", i, tx, fr[i]); end
    end
    repeat (3) @(negedge clk);
    read_status(s);
    total++;
    if (s[2] !== 1'b1) begin bad++; $display("FAIL single_busy39 got=%b exp=1", s[2]); end
    @(negedge clk);
    read_status(s);
    total++;
    if (s !== 32'h2) begin bad++; $display("FAIL single_idle40 got=%h exp=00000002", s); end
    wait_idle(20, "single");
  endtask

  task automatic test_back_to_back();
    logic [31:0] s;
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h0F);
    bus_write(BASE, 32'h55);
    bus_write(BASE, 32'h0F);
    bus_idle();
    #1;
    total++;
    if (tx !== 1'b0) begin bad++; $display("FAIL b2b_start0 got=%b exp=0", tx); end
    repeat (39) @(negedge clk);
    #1;
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL b2b_stop39 got=%b exp=1", tx); end
    @(negedge clk);
    #1;
    total++;
    if (tx !== 1'b0) begin bad++; $display("FAIL b2b_start40 got=%b exp=0", tx); end
    repeat (39) @(negedge clk);
    read_status(s);
    total++;
    if (s[2] !== 1'b1) begin bad++; $display("FAIL b2b_busy79 got=%b exp=1", s[2]); end
    @(negedge clk);
    read_status(s);
    total++;
    if (s !== 32'h2 || tx !== 1'b1) begin
      bad++; $display("FAIL b2b_idle80 got=%h/%b exp=00000002/1", s, tx);
    end
    wait_idle(20, "b2b");
  endtask

  task automatic test_full_overflow();
    logic [31:0] s;
    for (int i = 1; i <= 5; i++) exp_q.push_back(8'(i * 8'h11));
    bus_write(BASE, 32'h11);
    bus_idle();
    @(negedge clk);
    for (int i = 2; i <= 6; i++) bus_write(BASE, 32'(i * 8'h11));
    bus_idle();
    read_status(s);
    total++;
    if (s !== 32'h0000_040D) begin bad++; $display("FAIL full_status got=%h exp=0000040d", s); end
    bus_write(ST_ADDR, 32'hFFFF_FFFF);
    bus_idle();
    read_status(s);
    total++;
    if (s !== 32'h0000_0405) begin bad++; $display("FAIL ovf_clear got=%h exp=00000405", s); end
    wait_idle(400, "overflow");
    repeat (60) @(negedge clk);
    read_status(s);
    total++;
    if (s !== 32'h2) begin bad++; $display("FAIL overflow_drain got=%h exp=00000002", s); end
  endtask

  task automatic test_decode();
    logic [31:0] s;
    @(negedge clk);
    we = 1'b1; a = BASE + 32'd8; wd = 32'h77;
    #1;
    total++;
    if (hit !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL decode_plus8 got=%b/%h exp=0/0", hit, rd); end
    @(negedge clk);
    a = BASE - 32'd4;
    #1;
    total++;
    if (hit !== 1'b0 || rd !== 32'h0) begin bad++; $display("FAIL decode_minus4 got=%b/%h exp=0/0", hit, rd); end
    @(negedge clk);
    we = 1'b0; a = BASE + 32'd3;
    #1;
    total++;
    if (hit !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL decode_data_read got=%b/%h exp=1/0", hit, rd); end
    read_status(s);
    total++;
    if (s !== 32'h2) begin bad++; $display("FAIL decode_no_push got=%h exp=00000002", s); end
    repeat (20) @(negedge clk);
    total++;
    if (tx !== 1'b1) begin bad++; $display("FAIL decode_no_frame got=%b exp=1", tx); end
  endtask

  task automatic test_wrap();
    logic [31:0] s;
    int batch [4] = '{3, 3, 3, 1};
    int v = 0;
    for (int b = 0; b < 4; b++) begin
      for (int j = 0; j < batch[b]; j++) begin
        exp_q.push_back(8'(v));
        bus_write(BASE, 32'(v));
        v++;
      end
      bus_idle();
      wait_idle(300, "wrap");
    end
    read_status(s);
    total++;
    if (s !== 32'h2) begin bad++; $display("FAIL wrap_final got=%h exp=00000002", s); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_overflow();
    test_decode();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/ucsbece154a_uart_tx.md
# ucsbece154a_uart_tx

Memory-mapped UART transmitter sitting downstream of the multicycle RISC-V core on the same bus as data memory (we/a/wd/rd). It decodes a small register window, buffers stored bytes in a FIFO, and serializes them 8N1 on a single TX line. The top level routes processor writes to it in parallel with memory and selects its read data when `hit_o` is high.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000: base of the 8-byte register window (word-aligned).
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit, at least 2.
- `FIFO_DEPTH`, default 8: byte entries, a power of two, at least 2.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high.
- `we_i` input 1: bus write enable (processor MemWrite).
- `a_i` input 32: bus address.
- `wd_i` input 32: bus write data.
- `rd_o` output 32: read data for a decoded address, 0 otherwise; combinational.
- `hit_o` output 1: `a_i[31:3] == BASE_ADDR[31:3]`; combinational.
- `tx_o` output 1: serial line, idle high; registered.

## Operation
- Register map (word offsets; `a_i[1:0]` ignored):
  - +0 DATA: a write pushes `wd_i[7:0]`. Reads return 0.
  - +4 STATUS: bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky). Bits [7+k:8] hold the FIFO count, where k = log2(FIFO_DEPTH)+1. All other bits are 0. Any write to STATUS clears overflow.
- Push rule:
  - A push is the edge where `we_i`, `hit_o` and offset +0 are all true.
  - If the FIFO is full before the edge, the byte is dropped and overflow is set. This holds even if a pop happens on the same edge.
- FIFO:
  - Circular buffer with read/write pointers that wrap modulo FIFO_DEPTH.
  - The count register is one bit wider than the pointers.
  - A push and pop on the same edge leave the count unchanged.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx_o`=1. If the FIFO is not empty, pop the head into the shift register, clear the bit and baud counters, and go to START.
  - START: `tx_o`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx_o` = shift[0] (LSB first). Every CLKS_PER_BIT cycles, shift right and increment the bit counter. After the 8th bit, go to STOP.
  - STOP: `tx_o`=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is not empty, pop and go straight to START (no idle gap). Otherwise go to IDLE.
- `tx_o` is a register loaded from the next-state decode, so it has no combinational glitches.
- Reset (asynchronous, any time, including mid-frame):
  - FSM to IDLE, `tx_o`=1.
  - FIFO emptied (pointers and count to 0), overflow cleared, counters cleared.
  - The frame in flight is abandoned.

## Timing
- Reset values: `tx_o`=1. STATUS reads 32'h0000_0002 (empty only). `rd_o` and `hit_o` follow `a_i` combinationally.
- Latency: with an empty FIFO and IDLE, a push at edge N gives pop and START at edge N+1, so `tx_o` falls after edge N+1.
- Frame length is exactly 10×CLKS_PER_BIT cycles. Back-to-back frames have no gap.
- STATUS reflects register state before the current edge. A read in the same cycle as a push shows the pre-push count.
- The core's single-cycle bus access is always accepted. There is no stall or ready signal; software polls STATUS.full.

## Structure
- Shared package `ucsbece154a_uart_pkg`:
  - FSM state enum (UART_IDLE/START/DATA/STOP).
  - Register offset constants (UART_DATA_OFS=0, UART_STATUS_OFS=4).
  - STATUS bit index constants.
- One sub-module, `ucsbece154a_fifo` (parameterised width and depth; push, pop, full, empty, count), instantiated with width 8.
- The bus decode and the FSM stay in `ucsbece154a_uart_tx`.
- At the top level, `rd` is muxed as `hit_o ? uart rd_o : mem rd_o`. Memory writes are gated with `!hit_o`.

## Test plan
Use CLKS_PER_BIT=4 and FIFO_DEPTH=4 unless stated otherwise.
- **Reset state:** assert reset mid-frame. Expect `tx_o`=1 immediately, asynchronously. After release, STATUS reads 32'h2.
- **Single byte:** write 32'h0000_00A5 to BASE+0. Expect `tx_o` to fall after edge N+1. Sampling every 4 cycles gives 0,1,0,1,0,0,1,0,1,1. Expect IDLE after 40 cycles.
- **Back-to-back:** push 8'h55 then 8'h0F on consecutive cycles. Expect two frames totalling 80 cycles, with the second start bit immediately after the first stop bit.
- **Full and overflow:** with the FSM busy, push 6 bytes. The first goes to the shift register and 4 are queued. Expect STATUS full=1, count=4, overflow=1, and the 6th byte never transmitted. A write to BASE+4 then clears overflow only.
- **Decode:** write to BASE+8 and to BASE-4. Expect `hit_o`=0 and no FIFO change. A read of BASE+0 returns 0.
- **Wrap:** push and drain 10 bytes (0x00..0x09) in batches of 3. Verify order preserved across pointer wrap, with count returning to 0 and empty=1.
